gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Self-test initiator for the two-input gate library cells (AND, NAND, XNOR). It drives the shared A/B inputs through all four input vectors and samples each gate's Y output after a programmable settle time. It compares each output against the expected truth table and reports a pass/fail summary. It sits beside the gate cells as their stimulus and checking end, and is used in bring-up and regression.

Parameters:
SETTLE_CYCLES, 2, clocks between driving a vector and sampling Y; legal range 1..15
NUM_PASSES, 1, number of full 4-vector sweeps per start; legal range 1..255

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a sweep; sampled only in IDLE
a_out  output  1  drive to gate input A
b_out  output  1  drive to gate input B
and_y  input  1  AND cell output
nand_y  input  1  NAND cell output
xnor_y  input  1  XNOR cell output
busy  output  1  high from the first SETTLE cycle through the last SAMPLE cycle
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 if err_count==0; valid from done, held until next start
err_count  output  8  mismatch count, saturating at 255
fail_vec  output  3  sticky per-gate fail: [0]=AND, [1]=NAND, [2]=XNOR
first_fail  output  2  {a,b} of the first vector with any mismatch
first_fail_valid  output  1  first_fail is meaningful

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, first_fail=0, first_fail_valid=0.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → vector index v=0 ({a_out,b_out}=00), settle counter=SETTLE_CYCLES-1, pass counter=0.
  - The same start also clears err_count, fail_vec, pass, first_fail and first_fail_valid. Next state SETTLE.
- SETTLE:
  - While counter>0, decrement.
  - At counter==0, go to SAMPLE. The SETTLE dwell is exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - Expected values: AND=a&b, NAND=~(a&b), XNOR=~(a^b), computed from the registered a_out/b_out.
  - Each mismatching gate adds 1 to err_count, so 0..3 per vector.
  - err_count saturates at 255 and never wraps.
  - Each mismatch sets its fail_vec bit.
  - On the first vector with any mismatch, latch first_fail={a_out,b_out} and set first_fail_valid. Later mismatches do not overwrite it.
  - If v==3 and pass counter==NUM_PASSES-1 → DONE.
  - Otherwise v=v+1, wrapping 3→0; on wrap, pass counter +1. Drive the new vector, reload the settle counter, go to SETTLE.
- DONE (one cycle):
  - done=1, pass=(err_count==0) using the final count including the last sample.
  - busy=0, a_out=b_out=0. Next state IDLE.
- Latency:
  - start sampled at edge 0 → done high in cycle 1 + 4·NUM_PASSES·(SETTLE_CYCLES+1).
  - This is cycle 13 for default parameters.
- Boundary rules:
  - start while busy or in DONE is ignored, with no restart and no clear.
  - start held high continuously re-triggers only on return to IDLE.
  - rst mid-sweep returns everything immediately to reset values. No done pulse is produced.
  - Results (pass, err_count, fail_vec, first_fail*) hold their values in IDLE until the next accepted start.

Decomposition:
- Package gate_chk_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - gate index constants GATE_AND=0, GATE_NAND=1, GATE_XNOR=2
  - ERR_MAX=255
  - function expected_y(a,b) returning the 3-bit expected vector
- No sub-module. The settle counter and saturating error counter stay inline.

Test Plan:
1. Wire to correct AND/NAND/XNOR cells, defaults, pulse start → done at cycle 13, pass=1, err_count=0, fail_vec=000, first_fail_valid=0; a_out/b_out sequence 00,01,10,11.
2. and_y stuck at 0 → err_count=1, fail_vec=001, first_fail=11, first_fail_valid=1, pass=0.
3. nand_y driven from the AND output → err_count=4, fail_vec=010, first_fail=00.
4. Assert rst at cycle 6 of a sweep:
   - All outputs return to reset values asynchronously, and no done pulse follows.
   - A fresh start then completes normally at +13 cycles.
5. NUM_PASSES=64, xnor_y inverted:
   - 256 mismatches occur, err_count saturates at 255, fail_vec=100, first_fail=00.
   - done at cycle 1+64·12=769.
6. SETTLE_CYCLES=1:
   - Extra start pulses mid-sweep are ignored.
   - done appears exactly once, at cycle 9, and is one cycle wide.
   - Results hold unchanged for 20 idle cycles afterwards.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate sweep checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit positions of each gate inside the 3-bit result/fail vectors
    localparam int GATE_AND  = 0;
    localparam int GATE_NAND = 1;
    localparam int GATE_XNOR = 2;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Truth-table reference for the three gate cells at input (a,b)
    function automatic logic [2:0] expected_y(input logic a, input logic b);
        logic [2:0] y;
        y            = 3'b000;
        y[GATE_AND]  = a & b;
        y[GATE_NAND] = ~(a & b);
        y[GATE_XNOR] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Sweeps {a,b} through 00,01,10,11 for NUM_PASSES passes, samples the AND,
// NAND and XNOR cell outputs after SETTLE_CYCLES clocks per vector and
// accumulates a mismatch summary. Every output is a flop.
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_y,
    input  logic       nand_y,
    input  logic       xnor_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_vec,
    output logic [1:0] first_fail,
    output logic       first_fail_valid
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] pass_cnt, pass_cnt_nx;
    logic       a_nx, b_nx, busy_nx, done_nx, pass_nx, ffv_nx;
    logic [7:0] err_nx;
    logic [2:0] fail_vec_nx;
    logic [1:0] ff_nx;

    // The applied vector is the registered a/b pair itself
    logic [1:0] vec, vec_inc;
    logic [2:0] miss;
    logic [1:0] miss_cnt;
    logic [8:0] err_sum;
    logic [7:0] err_sat;

    assign vec      = {a_out, b_out};
    assign vec_inc  = 2'(vec + 2'd1);
    assign miss     = {xnor_y, nand_y, and_y} ^ expected_y(a_out, b_out);
    assign miss_cnt = 2'(miss[GATE_AND]) + 2'(miss[GATE_NAND]) + 2'(miss[GATE_XNOR]);
    assign err_sum  = 9'(err_count) + 9'(miss_cnt);
    assign err_sat  = (err_sum > 9'(ERR_MAX)) ? ERR_MAX : err_sum[7:0];

    // Next-state and next-output decode; results hold unless a sample or an accepted start changes them
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pass_cnt_nx = pass_cnt;
        a_nx        = a_out;
        b_nx        = b_out;
        busy_nx     = busy;
        done_nx     = 1'b0;
        pass_nx     = pass;
        err_nx      = err_count;
        fail_vec_nx = fail_vec;
        ff_nx       = first_fail;
        ffv_nx      = first_fail_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nx        = 1'b0;
                    b_nx        = 1'b0;
                    cnt_nx      = SETTLE_LOAD;
                    pass_cnt_nx = 8'd0;
                    busy_nx     = 1'b1;
                    pass_nx     = 1'b0;
                    err_nx      = 8'd0;
                    fail_vec_nx = 3'b000;
                    ff_nx       = 2'b00;
                    ffv_nx      = 1'b0;
                    state_nx    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else             state_nx = SAMPLE;
            end
            SAMPLE: begin
                err_nx      = err_sat;
                fail_vec_nx = fail_vec | miss;
                if ((miss != 3'b000) && !first_fail_valid) begin
                    ff_nx  = vec;
                    ffv_nx = 1'b1;
                end
                if ((vec == 2'd3) && (pass_cnt == LAST_PASS)) begin
                    done_nx  = 1'b1;
                    pass_nx  = (err_sat == 8'd0);
                    busy_nx  = 1'b0;
                    a_nx     = 1'b0;
                    b_nx     = 1'b0;
                    state_nx = DONE;
                end else begin
                    if (vec == 2'd3) pass_cnt_nx = pass_cnt + 8'd1;
                    a_nx     = vec_inc[1];
                    b_nx     = vec_inc[0];
                    cnt_nx   = SETTLE_LOAD;
                    state_nx = SETTLE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and all outputs; reset drops everything at once with no done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            pass_cnt         <= 8'd0;
            a_out            <= 1'b0;
            b_out            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 8'd0;
            fail_vec         <= 3'b000;
            first_fail       <= 2'b00;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            pass_cnt         <= pass_cnt_nx;
            a_out            <= a_nx;
            b_out            <= b_nx;
            busy             <= busy_nx;
            done             <= done_nx;
            pass             <= pass_nx;
            err_count        <= err_nx;
            fail_vec         <= fail_vec_nx;
            first_fail       <= ff_nx;
            first_fail_valid <= ffv_nx;
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (defaults, 64 passes,
// settle=1) each driving modelled gate cells whose outputs can be flipped
// per vector. A driver issues sweeps and queues expected summaries; a
// single monitor checks per-cycle activity and the summary at done.
module tb_gate_sweep_checker;

    typedef struct {
        int id;
        int start;
        int err;
        int fv;
        int ff;
        int ffv;
        int pass;
    } res_t;

    logic       clk;
    logic       rst    [3];
    logic       start  [3];
    logic       a_o    [3];
    logic       b_o    [3];
    logic       and_y  [3];
    logic       nand_y [3];
    logic       xnor_y [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic [7:0] err_o  [3];
    logic [2:0] fv_o   [3];
    logic [1:0] ff_o   [3];
    logic       ffv_o  [3];

    // Per instance, per {a,b} vector: which gate outputs are wrong (bit0 AND, bit1 NAND, bit2 XNOR)
    logic [2:0] mask [3][4];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic tmo = 1'b0;
    res_t q[$];
    res_t hold [3];

    function automatic int sc(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int np(input int i);
        return (i == 1) ? 64 : 1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        // Gate cells: ideal truth table, optionally corrupted per applied vector
        assign and_y[g]  = (a_o[g] & b_o[g])    ^ mask[g][{a_o[g], b_o[g]}][0];
        assign nand_y[g] = ~(a_o[g] & b_o[g])   ^ mask[g][{a_o[g], b_o[g]}][1];
        assign xnor_y[g] = ~(a_o[g] ^ b_o[g])   ^ mask[g][{a_o[g], b_o[g]}][2];

        gate_sweep_checker #(
            .SETTLE_CYCLES((g == 2) ? 1 : 2),
            .NUM_PASSES((g == 1) ? 64 : 1)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .start(start[g]),
            .a_out(a_o[g]),
            .b_out(b_o[g]),
            .and_y(and_y[g]),
            .nand_y(nand_y[g]),
            .xnor_y(xnor_y[g]),
            .busy(busy_o[g]),
            .done(done_o[g]),
            .pass(pass_o[g]),
            .err_count(err_o[g]),
            .fail_vec(fv_o[g]),
            .first_fail(ff_o[g]),
            .first_fail_valid(ffv_o[g])
        );
    end

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Summary from the fault masks: every pass repeats the same mismatches
    function automatic res_t model(input int id, input int st);
        res_t r;
        int   per_pass;
        r = '{id: id, start: st, err: 0, fv: 0, ff: 0, ffv: 0, pass: 0};
        per_pass = 0;
        for (int v = 0; v < 4; v++) begin
            per_pass += $countones(mask[id][v]);
            r.fv |= int'(mask[id][v]);
            if (r.ffv == 0 && mask[id][v] != 3'b000) begin
                r.ff  = v;
                r.ffv = 1;
            end
        end
        r.err  = (per_pass * np(id) > 255) ? 255 : per_pass * np(id);
        r.pass = (per_pass == 0) ? 1 : 0;
        return r;
    endfunction

    // Monitor: reset values, per-cycle sweep activity, summary at done, idle hold
    always @(negedge clk) begin
        if (tmo) chk("wait_bound", int'(tmo), 0);
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                while (q.size() > 0 && q[0].id == i) void'(q.pop_front());
                hold[i] = '{id: i, start: 0, err: 0, fv: 0, ff: 0, ffv: 0, pass: 0};
                chk($sformatf("d%0d rst ab", i), int'({a_o[i], b_o[i]}), 0);
                chk($sformatf("d%0d rst busy/done", i), int'({busy_o[i], done_o[i]}), 0);
                chk($sformatf("d%0d rst results", i),
                    int'({pass_o[i], err_o[i], fv_o[i], ff_o[i], ffv_o[i]}), 0);
            end else if (q.size() > 0 && q[0].id == i && cyc >= q[0].start) begin
                res_t e;
                int   len;
                e   = q[0];
                len = 4 * np(i) * (sc(i) + 1);
                if (cyc < e.start + len) begin
                    chk($sformatf("d%0d busy", i), int'(busy_o[i]), 1);
                    chk($sformatf("d%0d early done", i), int'(done_o[i]), 0);
                    chk($sformatf("d%0d vector", i), int'({a_o[i], b_o[i]}),
                        ((cyc - e.start) / (sc(i) + 1)) % 4);
                end else begin
                    chk($sformatf("d%0d done at latency", i), int'(done_o[i]), 1);
                    chk($sformatf("d%0d busy at done", i), int'(busy_o[i]), 0);
                    chk($sformatf("d%0d ab at done", i), int'({a_o[i], b_o[i]}), 0);
                    chk($sformatf("d%0d pass", i), int'(pass_o[i]), e.pass);
                    chk($sformatf("d%0d err_count", i), int'(err_o[i]), e.err);
                    chk($sformatf("d%0d fail_vec", i), int'(fv_o[i]), e.fv);
                    chk($sformatf("d%0d first_fail_valid", i), int'(ffv_o[i]), e.ffv);
                    if (e.ffv != 0) chk($sformatf("d%0d first_fail", i), int'(ff_o[i]), e.ff);
                    hold[i] = e;
                    void'(q.pop_front());
                end
            end else begin
                chk($sformatf("d%0d idle done", i), int'(done_o[i]), 0);
                chk($sformatf("d%0d idle busy", i), int'(busy_o[i]), 0);
                chk($sformatf("d%0d idle ab", i), int'({a_o[i], b_o[i]}), 0);
                chk($sformatf("d%0d hold pass", i), int'(pass_o[i]), hold[i].pass);
                chk($sformatf("d%0d hold err", i), int'(err_o[i]), hold[i].err);
                chk($sformatf("d%0d hold fail_vec", i), int'(fv_o[i]), hold[i].fv);
                chk($sformatf("d%0d hold ffv", i), int'(ffv_o[i]), hold[i].ffv);
                if (hold[i].ffv != 0) chk($sformatf("d%0d hold first_fail", i), int'(ff_o[i]), hold[i].ff);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int id, input logic [2:0] m0, input logic [2:0] m1,
                            input logic [2:0] m2, input logic [2:0] m3);
        mask[id][0] = m0;
        mask[id][1] = m1;
        mask[id][2] = m2;
        mask[id][3] = m3;
    endtask

    // mode 0 plain, 1 extra start pulse mid-sweep, 2 reset mid-sweep, 3 start held for two sweeps.
    // arg picks the edge offset for modes 1/2 (0 = random).
    task automatic sweep(input int id, input int mode, input int arg);
        int   e0, len, p, n;
        res_t r;
        len = 4 * np(id) * (sc(id) + 1);
        start[id] = 1'b1;
        tick();
        e0 = cyc;
        if (mode == 3) begin
            r = model(id, e0);
            q.push_back(r);
            r = model(id, e0 + len + 2);
            q.push_back(r);
            repeat (len + 2) tick();
            start[id] = 1'b0;
        end else begin
            start[id] = 1'b0;
            r = model(id, e0);
            q.push_back(r);
        end
        if (mode == 1) begin
            p = (arg != 0) ? arg : $urandom_range(1, len + 1);
            repeat (p - 1) tick();
            start[id] = 1'b1;
            tick();
            start[id] = 1'b0;
        end else if (mode == 2) begin
            p = (arg != 0) ? arg : $urandom_range(1, len - 1);
            repeat (p) tick();
            #1 rst[id] = 1'b1;
            tick();
            rst[id] = 1'b0;
        end
        n = 0;
        while (q.size() > 0 && n < len + 10) begin
            tick();
            n++;
        end
        if (q.size() > 0) tmo = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
            set_mask(i, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        repeat (2) tick();

        // Healthy cells: pass, zero errors, vectors 00,01,10,11
        sweep(0, 0, 0);
        // AND stuck at 0: only the 11 vector disagrees
        set_mask(0, 3'b000, 3'b000, 3'b000, 3'b001);
        sweep(0, 0, 0);
        // NAND wired to the AND output: wrong on every vector
        set_mask(0, 3'b010, 3'b010, 3'b010, 3'b010);
        sweep(0, 0, 0);
        // Reset part-way through, then a clean sweep
        sweep(0, 2, 5);
        repeat (10) tick();
        set_mask(0, 3'b000, 3'b000, 3'b000, 3'b000);
        sweep(0, 0, 0);
        // 64 passes with XNOR inverted: 256 mismatches saturate at 255
        set_mask(1, 3'b100, 3'b100, 3'b100, 3'b100);
        sweep(1, 0, 0);
        // Settle of one cycle, stray starts ignored, results hold while idle
        sweep(2, 1, 2);
        sweep(2, 1, 5);
        repeat (20) tick();
        set_mask(2, 3'b000, 3'b110, 3'b000, 3'b000);
        sweep(2, 3, 0);

        // Random faults and scenarios on the short-sweep instances
        for (int k = 0; k < 30; k++) begin
            int id;
            id = ($urandom_range(0, 1) == 0) ? 0 : 2;
            for (int v = 0; v < 4; v++)
                mask[id][v] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            sweep(id, $urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 4)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
